// File: rtl/x_simprim_pkg.sv
// Shared definitions for the simprim serial cells: FSM state encoding,
// parameter legality and counter sizing.
`timescale 1ps/1ps
package x_simprim_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  function automatic bit width_ok(input int w);
    return (w >= 2) && (w <= 64);
  endfunction

  // Bits needed to count 0..w-1; never less than one.
  function automatic int cnt_w(input int w);
    int r;
    r = 1;
    for (int k = 1; k <= 7; k++)
      if ((1 << k) < w) r = k + 1;
    return r;
  endfunction

endpackage

// File: rtl/x_and16_ser_cnt.sv
// Mod-WIDTH bit counter with enable, synchronous clear and terminal count.
`timescale 1ps/1ps
module x_and16_ser_cnt
  import x_simprim_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int CW = cnt_w(WIDTH)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  assign tc = (cnt == CW'(WIDTH - 1));

  // Wrap is forced at terminal count so non-power-of-2 widths never overrun.
  always_ff @(posedge clk) begin
    if (clr)     cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/x_and16_ser.sv
// Bit-serial wide-AND evaluator and deserializer: WIDTH accepted bits,
// LSB first, yield the AND-reduction and the captured word.
`timescale 1ps/1ps
`celldefine
module x_and16_ser
  import x_simprim_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             I,
  input  logic             I_VLD,
  output logic             I_RDY,
  output logic             O,
  output logic [WIDTH-1:0] O_VEC,
  output logic             O_VLD,
  input  logic             O_RDY
);

  localparam int CW = cnt_w(WIDTH);

  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("x_and16_ser: WIDTH must be in 2..64");
    end
  endgenerate

  state_t           state;
  logic             acc;
  logic [WIDTH-1:0] vec;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             in_xfer;
  logic             out_xfer;

  assign I_RDY    = (state == COLLECT) & CE & ~RST;
  assign O_VLD    = (state == HOLD) & CE & ~RST;
  assign in_xfer  = I_VLD & I_RDY;
  assign out_xfer = O_VLD & O_RDY;

  x_and16_ser_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk (CLK),
    .clr (RST),
    .en  (in_xfer),
    .cnt (cnt),
    .tc  (tc)
  );

  // vec is cleared per word, so OR-ing the new bit into place is a write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= COLLECT;
      acc   <= 1'b1;
      vec   <= '0;
      O     <= 1'b0;
      O_VEC <= '0;
    end else begin
      case (state)
        COLLECT: if (in_xfer) begin
          if (tc) begin
            O     <= acc & I;
            O_VEC <= {I, vec[WIDTH-2:0]};
            acc   <= 1'b1;
            vec   <= '0;
            state <= HOLD;
          end else begin
            vec <= vec | (WIDTH'(I) << cnt);
            acc <= acc & I;
          end
        end
        HOLD: if (out_xfer) state <= COLLECT;
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
`endcelldefine

// File: tb/tb_x_and16_ser.sv
// Directed bench for x_and16_ser at WIDTH=16 and WIDTH=5.
`timescale 1ps/1ps
module tb_x_and16_ser;

  logic        clk = 1'b0;
  logic        rst, ce, o_rdy;
  logic        i, i_vld, i_rdy, o, o_vld;
  logic [15:0] o_vec;
  logic        i5, i_vld5, i_rdy5, o5, o_vld5;
  logic [4:0]  o_vec5;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  x_and16_ser #(.WIDTH(16)) dut (
    .CLK(clk), .RST(rst), .CE(ce), .I(i), .I_VLD(i_vld), .I_RDY(i_rdy),
    .O(o), .O_VEC(o_vec), .O_VLD(o_vld), .O_RDY(o_rdy)
  );

  x_and16_ser #(.WIDTH(5)) dut5 (
    .CLK(clk), .RST(rst), .CE(ce), .I(i5), .I_VLD(i_vld5), .I_RDY(i_rdy5),
    .O(o5), .O_VEC(o_vec5), .O_VLD(o_vld5), .O_RDY(o_rdy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends on a falling edge; bits go back-to-back.
  task automatic send_word(input logic [15:0] w);
    for (int k = 0; k < 16; k++) begin
      i = w[k]; i_vld = 1'b1;
      @(negedge clk);
    end
    i_vld = 1'b0;
  endtask

  task automatic send5(input logic [4:0] w);
    for (int k = 0; k < 5; k++) begin
      i5 = w[k]; i_vld5 = 1'b1;
      @(negedge clk);
    end
    i_vld5 = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ce = 1'b1; o_rdy = 1'b1;
    i = 1'b0; i_vld = 1'b0; i5 = 1'b0; i_vld5 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_i_rdy", i_rdy, 0);
    chk("rst_o_vld", o_vld, 0);
    chk("rst_o", o, 0);
    chk("rst_o_vec", o_vec, 0);
    rst = 1'b0;
    #1 chk("first_i_rdy", i_rdy, 1);

    // all ones, back-to-back: result visible in cycle 17
    send_word(16'hFFFF);
    chk("ones_o_vld", o_vld, 1);
    chk("ones_i_rdy", i_rdy, 0);
    chk("ones_o", o, 1);
    chk("ones_o_vec", o_vec, 16'hFFFF);
    @(negedge clk);
    chk("ones_back_collect", i_rdy, 1);
    chk("ones_o_vld_drop", o_vld, 0);
    chk("ones_o_retained", o_vec, 16'hFFFF);

    // single zero at bit 9
    send_word(16'hFDFF);
    chk("zero9_o", o, 0);
    chk("zero9_o_vec", o_vec, 16'hFDFF);
    @(negedge clk);

    // backpressure for 5 cycles with a source offering bits
    o_rdy = 1'b0;
    send_word(16'hA5A5);
    i = 1'b1; i_vld = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_o_vld", o_vld, 1);
      chk("bp_o", o, 0);
      chk("bp_o_vec", o_vec, 16'hA5A5);
      chk("bp_i_rdy", i_rdy, 0);
      @(negedge clk);
    end
    i_vld = 1'b0;
    o_rdy = 1'b1;
    @(negedge clk);
    chk("bp_release_i_rdy", i_rdy, 1);
    send_word(16'h8001);
    chk("bp_next_o_vec", o_vec, 16'h8001);
    chk("bp_next_o", o, 0);
    @(negedge clk);

    // I_VLD gaps plus a 3-cycle CE stall mid-word offering wrong bits
    for (int k = 0; k < 16; k++) begin
      i = k[0] ^ k[2]; i_vld = 1'b1;
      @(negedge clk);
      if (k == 15) break;
      i_vld = 1'b0;
      if (k == 7) begin
        ce = 1'b0; i_vld = 1'b1; i = 1'b1;
        repeat (3) begin
          #1 chk("ce_i_rdy", i_rdy, 0);
          chk("ce_o_vld", o_vld, 0);
          @(negedge clk);
        end
        ce = 1'b1; i_vld = 1'b0;
      end
      @(negedge clk);
    end
    i_vld = 1'b0;
    // bit k = k[0]^k[2]: pattern 0,1,0,1,1,0,1,0 repeated
    chk("gap_o_vld", o_vld, 1);
    chk("gap_o_vec", o_vec, 16'h5A5A);
    chk("gap_o", o, 0);
    ce = 1'b0;
    #1 chk("ce_hold_o_vld", o_vld, 0);
    @(negedge clk);
    ce = 1'b1;
    #1 chk("ce_hold_resume", o_vld, 1);
    @(negedge clk);

    // reset after 7 bits, with the source still driving
    for (int k = 0; k < 7; k++) begin
      i = 1'b1; i_vld = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    #1 chk("rst_mid_i_rdy", i_rdy, 0);
    @(negedge clk);
    chk("rst_mid_o", o, 0);
    chk("rst_mid_o_vec", o_vec, 0);
    rst = 1'b0; i_vld = 1'b0;
    send_word(16'hFFFF);
    chk("post_rst_o", o, 1);
    chk("post_rst_o_vec", o_vec, 16'hFFFF);
    @(negedge clk);

    // reset coinciding with the final transfer wins
    for (int k = 0; k < 15; k++) begin
      i = 1'b1; i_vld = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; i_vld = 1'b0;
    #1 chk("rst_final_o_vld", o_vld, 0);
    chk("rst_final_i_rdy", i_rdy, 1);
    chk("rst_final_o_vec", o_vec, 0);
    send_word(16'hFFFE);
    chk("rst_final_next", o_vec, 16'hFFFE);
    @(negedge clk);

    // WIDTH=5, consecutive words
    send5(5'h1F);
    chk("w5_a_o_vld", o_vld5, 1);
    chk("w5_a_o", o5, 1);
    chk("w5_a_o_vec", o_vec5, 5'h1F);
    @(negedge clk);
    send5(5'h1D);
    chk("w5_b_o", o5, 0);
    chk("w5_b_o_vec", o_vec5, 5'h1D);
    @(negedge clk);
    chk("w5_b_collect", i_rdy5, 1);
    send5(5'h0E);
    chk("w5_c_o_vec", o_vec5, 5'h0E);
    chk("w5_c_o", o5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
